bsg_scan_pipe: RTL and testbench
================================

// Module: bsg_scan_pipe
// PURPOSE
//  Pipelined, handshaked parallel-prefix (Kogge-Stone) scan with the operator and direction chosen per beat.
//  Sits between datapath stages that need prefix masks or parity chains at clock rates a combinational scan cannot meet.
//  Output bit k is the op-reduction of input bits [width_p-1:k] (hi_to_lo) or [k:0] (lo_to_hi).
// PARAMETERS
//  width_p      8  scan width in bits (>=1); L = $clog2(width_p) prefix levels
//  reg_every_p  1  pipeline register after every reg_every_p levels (>=1)
// PORTS
//  clk_i        in   1        single clock
//  reset_i      in   1        asynchronous, active-high reset
//  v_i          in   1        input beat valid
//  ready_o      out  1        block accepts beat when v_i & ready_o
//  data_i       in   width_p  operand
//  op_i         in   2        bsg_scan_pipe_pkg::scan_op_e: AND=0, OR=1, XOR=2; 3 is illegal
//  lo_to_hi_i   in   1        1: scan from bit 0 upward; 0: scan from MSB downward
//  last_i       in   1        marks the end of an accumulation run (used only with the macro)
//  v_o          out  1        output beat valid
//  yumi_i       in   1        consumer takes beat; legal only when v_o=1
//  data_o       out  width_p  scan result
// BEHAVIOUR
//  - Stages: S = max(1, ceil(L/reg_every_p)) register stages. The last level always feeds a register. width_p=1 gives S=1.
//  - Latency is exactly S cycles from acceptance to v_o when there is no stall. Throughput is 1 beat/cycle.
//  - Stall: global advance = ~v_o | yumi_i; ready_o = advance. All stages shift together, so bubbles are not collapsed.
//  - Each stage register holds {valid, data, op, lo_to_hi, last}. Op and direction travel with the beat.
//  - Direction: bit-reverse data_i at entry when lo_to_hi=1, and reverse again at exit.
//  - Level j combines t[j] with (t[j] >> 2^j), with fill equal to the op identity: AND fills 1, OR/XOR fill 0.
//  - Reset (async): all stage valids=0, v_o=0, data_o=0, ready_o=1 after release, and the carry state is cleared.
//  - Reset mid-operation: in-flight beats are discarded, with no partial output.
//  - Simultaneous events: an accept and a yumi in the same cycle is legal and produces full-rate flow.
//  - op_i=3: the beat passes through unchanged (data_o = data_i). Simulation-only $error when v_i & ready_o.
//  - yumi_i while v_o=0: simulation-only $error. No state changes.
// CONFIGURATION
//  `BSG_SCAN_PIPE_ACCUM_EN defined: adds cross-beat accumulation.
//   - carry_v/carry registers track the reduction of the previous beat (data_o bit 0 for hi_to_lo, MSB for lo_to_hi).
//   - On each yumi, if the beat's last=0 the carry loads that beat's final element, op and dir. If last=1, carry_v is cleared.
//   - The output stage applies data_o = op(carry, scan) bitwise when carry_v and op/dir match the carry's op/dir.
//     Otherwise the carry is ignored and the state restarts from this beat.
//   - Applying the carry adds no extra latency; it is combinational in the final stage.
//  Macro undefined: the carry logic is removed, last_i is ignored, and every beat is independent.
// STRUCTURE
//  bsg_scan_pipe_pkg:
//   - scan_op_e enum
//   - function scan_identity(op)
//   - function scan_combine(op,a,b)
//   - typedef of the stage payload struct (parameterised through the width localparam in the module)
//  Sub-module bsg_scan_pipe_level: one Kogge-Stone level, with shift distance as a parameter and a combinational op.
//   - The top level instantiates L of these and a generate-placed register every reg_every_p levels.
//  Bit reversal uses a generate loop; streaming operators are not used.
// TESTING
//  1. width 8, AND, hi_to_lo, data 8'b1101_1111 -> after S cycles v_o=1, data_o=8'b1100_0000.
//  2. XOR, hi_to_lo, 8'hFF -> 8'b1010_1010. Back-to-back OR lo_to_hi 8'b0000_0100 -> 8'b1111_1100 on the next cycle.
//  3. Hold yumi_i=0 for 5 cycles with 3 beats in flight -> ready_o=0, data_o stable. Release -> 3 beats in order, 1 per cycle.
//  4. Assert reset_i asynchronously mid-stream -> v_o=0 and data_o=0 immediately. The first beat after reset gives a correct result at latency S.
//  5. reg_every_p=2 and width 16 (S=2), then width 1 (S=1):
//     - a 1-bit XOR of 1 -> 1.
//     - latency checks match S.
//  6. ACCUM_EN, XOR hi_to_lo: beat A=8'h01 last=0 -> 8'h01, then beat B=8'h00 last=1 -> 8'hFF.
//     The next beat C=8'h00 -> 8'h00 (carry cleared).

Source files
------------

// File: rtl/bsg_scan_pipe_pkg.sv
// bsg_scan_pipe_pkg
//   Shared types and helpers for the pipelined prefix-scan block.
//   - scan_op_e     : per-beat scan operator (AND/OR/XOR, 3 is illegal)
//   - scan_ctl_s    : control fields that travel with every beat
//   - scan_levels   : number of Kogge-Stone levels for a width
//   - scan_stages   : number of pipeline register stages
//   - scan_identity : fill value that leaves an operand unchanged
//   - scan_combine  : one-bit operator application
package bsg_scan_pipe_pkg;

  localparam int SCAN_OP_W = 2;

  typedef enum logic [SCAN_OP_W-1:0] {
    SCAN_AND     = 2'd0,
    SCAN_OR      = 2'd1,
    SCAN_XOR     = 2'd2,
    SCAN_ILLEGAL = 2'd3
  } scan_op_e;

  typedef struct packed {
    logic     v;
    scan_op_e op;
    logic     lo_to_hi;
    logic     last;
  } scan_ctl_s;

  function automatic int scan_levels(input int width);
    return (width <= 1) ? 0 : $clog2(width);
  endfunction

  // A width-1 scan has no levels but still owns one register stage.
  function automatic int scan_stages(input int levels, input int reg_every);
    if (levels == 0) return 1;
    return (levels + reg_every - 1) / reg_every;
  endfunction

  function automatic logic scan_identity(input scan_op_e op);
    return (op == SCAN_AND);
  endfunction

  // The illegal op returns the first operand, which makes the whole
  // scan a pass-through for that beat.
  function automatic logic scan_combine(input scan_op_e op, input logic a, input logic b);
    logic r;
    case (op)
      SCAN_AND: r = a & b;
      SCAN_OR:  r = a | b;
      SCAN_XOR: r = a ^ b;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bsg_scan_pipe_if.sv
// bsg_scan_pipe_if
//   Beat interface of bsg_scan_pipe.
//   Input side : v_i, ready_o, data_i, op_i, lo_to_hi_i, last_i
//   Output side: v_o, yumi_i, data_o
//   master modport: the environment (producer and consumer)
//   slave modport : the scan block
interface bsg_scan_pipe_if #(
  parameter int width_p = 8
);
  logic                          v_i;
  logic                          ready_o;
  logic [width_p-1:0]            data_i;
  bsg_scan_pipe_pkg::scan_op_e   op_i;
  logic                          lo_to_hi_i;
  logic                          last_i;
  logic                          v_o;
  logic                          yumi_i;
  logic [width_p-1:0]            data_o;

  modport master (
    output v_i, data_i, op_i, lo_to_hi_i, last_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, data_i, op_i, lo_to_hi_i, last_i, yumi_i,
    output ready_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_scan_pipe_level.sv
// bsg_scan_pipe_level
//   One Kogge-Stone level of a high-to-low scan: bit i combines with bit
//   i+dist_p; bits with no partner combine with the operator identity.
//   Ports: op_i (operator), data_i (level input), data_o (level output).
module bsg_scan_pipe_level
  import bsg_scan_pipe_pkg::*;
#(
  parameter int width_p = 8,
  parameter int dist_p  = 1
) (
  input  scan_op_e           op_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic fill;
  assign fill = scan_identity(op_i);

  for (genvar i = 0; i < width_p; i++) begin : g_bit
    if (i + dist_p < width_p) begin : g_pair
      assign data_o[i] = scan_combine(op_i, data_i[i], data_i[i+dist_p]);
    end else begin : g_edge
      assign data_o[i] = scan_combine(op_i, data_i[i], fill);
    end
  end

endmodule

// File: rtl/bsg_scan_pipe.sv
// bsg_scan_pipe
//   Pipelined Kogge-Stone prefix scan, operator and direction per beat.
//   Output bit k = op-reduction of data bits [width_p-1:k] (hi_to_lo) or
//   [k:0] (lo_to_hi). A register stage follows every reg_every_p levels and
//   always the last level.
//   Ports: clk_i, reset_i (async, active high), io (bsg_scan_pipe_if.slave).
//   Optional macro BSG_SCAN_PIPE_ACCUM_EN: carries the reduction of one beat
//   into the next until a beat marked last is consumed.
module bsg_scan_pipe
  import bsg_scan_pipe_pkg::*;
#(
  parameter int width_p     = 8,
  parameter int reg_every_p = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  bsg_scan_pipe_if.slave io
);

  localparam int levels_lp = scan_levels(width_p);
  localparam int stages_lp = scan_stages(levels_lp, reg_every_p);

  typedef struct packed {
    scan_ctl_s          ctl;
    logic [width_p-1:0] data;
  } stage_s;

  stage_s stage_q [stages_lp];
  stage_s stage_d [stages_lp];
  stage_s comb    [levels_lp+1];
  stage_s fin;
  logic   advance;

  // Handshake: a beat is accepted on a cycle with v_i & ready_o and taken
  // on a cycle with v_o & yumi_i. The pipe moves as one: every stage shifts
  // when the output is empty or being taken, so ready_o is that same
  // condition and bubbles keep their slots.
  assign fin        = stage_q[stages_lp-1];
  assign advance    = ~fin.ctl.v | io.yumi_i;
  assign io.ready_o = advance;
  assign io.v_o     = fin.ctl.v;

  // Low-to-high scans reuse the high-to-low network on reversed data.
  logic [width_p-1:0] data_rev_in;
  for (genvar i = 0; i < width_p; i++) begin : g_rev_in
    assign data_rev_in[i] = io.data_i[width_p-1-i];
  end

  assign comb[0] = '{
    ctl:  '{v: io.v_i, op: io.op_i, lo_to_hi: io.lo_to_hi_i, last: io.last_i},
    data: io.lo_to_hi_i ? data_rev_in : io.data_i
  };

  // Level j reads the register that closes the previous group when j starts
  // a new group, otherwise the combinational output of level j-1.
  for (genvar j = 0; j < levels_lp; j++) begin : g_level
    stage_s             src;
    logic [width_p-1:0] lvl_data;

    if (j != 0 && (j % reg_every_p) == 0) begin : g_from_reg
      assign src = stage_q[j/reg_every_p - 1];
    end else begin : g_from_comb
      assign src = comb[j];
    end

    bsg_scan_pipe_level #(
      .width_p (width_p),
      .dist_p  (1 << j)
    ) u_level (
      .op_i   (src.ctl.op),
      .data_i (src.data),
      .data_o (lvl_data)
    );

    assign comb[j+1] = '{ctl: src.ctl, data: lvl_data};
  end

  // Stage k captures the output of the last level of its group.
  for (genvar k = 0; k < stages_lp; k++) begin : g_stage_d
    localparam int tap_lp = ((k + 1) * reg_every_p < levels_lp) ?
                            (k + 1) * reg_every_p : levels_lp;
    assign stage_d[k] = comb[tap_lp];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < stages_lp; k++) stage_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < stages_lp; k++) stage_q[k] <= stage_d[k];
    end
  end

  logic [width_p-1:0] scan_rev;
  logic [width_p-1:0] scan_res;
  for (genvar i = 0; i < width_p; i++) begin : g_rev_out
    assign scan_rev[i] = fin.data[width_p-1-i];
  end
  assign scan_res = fin.ctl.lo_to_hi ? scan_rev : fin.data;

`ifdef BSG_SCAN_PIPE_ACCUM_EN
  logic     carry_v_q, carry_v_d;
  logic     carry_q, carry_d;
  scan_op_e carry_op_q, carry_op_d;
  logic     carry_dir_q, carry_dir_d;
  logic     carry_hit;
  logic     final_elem;
  logic [width_p-1:0] data_acc;

  // The carry only continues a run of the same operator and direction;
  // anything else starts fresh from the current beat.
  assign carry_hit = carry_v_q && (carry_op_q == fin.ctl.op) &&
                     (carry_dir_q == fin.ctl.lo_to_hi);

  for (genvar i = 0; i < width_p; i++) begin : g_acc
    assign data_acc[i] = carry_hit ? scan_combine(fin.ctl.op, scan_res[i], carry_q)
                                   : scan_res[i];
  end
  assign io.data_o = data_acc;

  // The full-width reduction sits at bit 0 for hi_to_lo, MSB for lo_to_hi.
  assign final_elem = fin.ctl.lo_to_hi ? data_acc[width_p-1] : data_acc[0];

  always_comb begin
    carry_v_d   = carry_v_q;
    carry_d     = carry_q;
    carry_op_d  = carry_op_q;
    carry_dir_d = carry_dir_q;
    if (fin.ctl.v && io.yumi_i) begin
      if (fin.ctl.last) begin
        carry_v_d = 1'b0;
      end else begin
        carry_v_d   = 1'b1;
        carry_d     = final_elem;
        carry_op_d  = fin.ctl.op;
        carry_dir_d = fin.ctl.lo_to_hi;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      carry_v_q   <= 1'b0;
      carry_q     <= 1'b0;
      carry_op_q  <= SCAN_AND;
      carry_dir_q <= 1'b0;
    end else begin
      carry_v_q   <= carry_v_d;
      carry_q     <= carry_d;
      carry_op_q  <= carry_op_d;
      carry_dir_q <= carry_dir_d;
    end
  end
`else
  // Without accumulation every beat stands alone and last is not consulted.
  logic unused_last;
  assign unused_last = fin.ctl.last;
  assign io.data_o   = scan_res;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.v_i && advance && io.op_i == SCAN_ILLEGAL))
        else $error("bsg_scan_pipe: illegal op accepted");
      assert (!(io.yumi_i && !fin.ctl.v))
        else $error("bsg_scan_pipe: yumi_i asserted while v_o is low");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_scan_pipe.sv
// tb_bsg_scan_pipe
//   Directed bench for bsg_scan_pipe at three configurations:
//   width 8 / reg every level (S=3), width 16 / reg every 2 (S=2),
//   width 1 (S=1). Covers the scan table, back-to-back flow, stall,
//   async reset mid-stream and (with BSG_SCAN_PIPE_ACCUM_EN) accumulation.
module tb_bsg_scan_pipe;
  import bsg_scan_pipe_pkg::*;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic       HI     = 1'b0;
  localparam logic       LO     = 1'b1;

`ifdef BSG_SCAN_PIPE_ACCUM_EN
  localparam logic [15:0] ACC_B_EXP = 16'h00FF;
`else
  localparam logic [15:0] ACC_B_EXP = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i;
  logic auto_yumi;
  always #5 clk = ~clk;

  bsg_scan_pipe_if #(.width_p(8))  if8 ();
  bsg_scan_pipe_if #(.width_p(16)) if16 ();
  bsg_scan_pipe_if #(.width_p(1))  if1 ();

  // The consumer only ever takes a beat that is actually presented.
  assign if8.yumi_i  = auto_yumi & if8.v_o;
  assign if16.yumi_i = auto_yumi & if16.v_o;
  assign if1.yumi_i  = auto_yumi & if1.v_o;

  bsg_scan_pipe #(.width_p(8),  .reg_every_p(1)) u_dut8  (.clk_i(clk), .reset_i(reset_i), .io(if8));
  bsg_scan_pipe #(.width_p(16), .reg_every_p(2)) u_dut16 (.clk_i(clk), .reset_i(reset_i), .io(if16));
  bsg_scan_pipe #(.width_p(1),  .reg_every_p(1)) u_dut1  (.clk_i(clk), .reset_i(reset_i), .io(if1));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int          sel;
    logic [1:0]  op;
    logic        dir;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input int sel, input logic v, input logic [1:0] op, input logic dir,
                       input logic last, input logic [15:0] d);
    if (sel == 0) begin
      if8.v_i = v; if8.op_i = scan_op_e'(op); if8.lo_to_hi_i = dir;
      if8.last_i = last; if8.data_i = d[7:0];
    end else if (sel == 1) begin
      if16.v_i = v; if16.op_i = scan_op_e'(op); if16.lo_to_hi_i = dir;
      if16.last_i = last; if16.data_i = d;
    end else begin
      if1.v_i = v; if1.op_i = scan_op_e'(op); if1.lo_to_hi_i = dir;
      if1.last_i = last; if1.data_i = d[0];
    end
  endtask

  function automatic logic get_vo(input int sel);
    if (sel == 0) return if8.v_o;
    if (sel == 1) return if16.v_o;
    return if1.v_o;
  endfunction

  function automatic logic get_ready(input int sel);
    if (sel == 0) return if8.ready_o;
    if (sel == 1) return if16.ready_o;
    return if1.ready_o;
  endfunction

  function automatic logic [15:0] get_do(input int sel);
    if (sel == 0) return {8'h00, if8.data_o};
    if (sel == 1) return if16.data_o;
    return {15'h0000, if1.data_o};
  endfunction

  function automatic int exp_lat(input int sel);
    if (sel == 0) return 3;
    if (sel == 1) return 2;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: accept it, count edges until v_o, check latency and data.
  task automatic run_beat(input string name, input int sel, input logic [1:0] op, input logic dir,
                          input logic last, input logic [15:0] d, input logic [15:0] exp);
    int cnt;
    drive(sel, 1'b1, op, dir, last, d);
    tick();
    drive(sel, 1'b0, op, dir, last, d);
    cnt = 1;
    while (!get_vo(sel) && cnt < 20) begin
      tick();
      cnt++;
    end
    check({name, " latency"}, 16'(cnt), 16'(exp_lat(sel)));
    check({name, " data"}, get_do(sel), exp);
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0]  = '{0, OP_AND, HI, 16'h00DF, 16'h00C0};
    tbl[1]  = '{0, OP_XOR, HI, 16'h00FF, 16'h00AA};
    tbl[2]  = '{0, OP_OR,  LO, 16'h0004, 16'h00FC};
    tbl[3]  = '{0, OP_OR,  HI, 16'h0004, 16'h0007};
    tbl[4]  = '{0, OP_AND, LO, 16'h00F7, 16'h0007};
    tbl[5]  = '{0, OP_XOR, LO, 16'h0081, 16'h007F};
    tbl[6]  = '{0, OP_XOR, HI, 16'h0081, 16'h00FE};
    tbl[7]  = '{0, OP_XOR, HI, 16'h0012, 16'h001C};
    tbl[8]  = '{0, OP_AND, LO, 16'h00FF, 16'h00FF};
    tbl[9]  = '{0, OP_OR,  HI, 16'h0000, 16'h0000};
    tbl[10] = '{1, OP_XOR, HI, 16'h8001, 16'hFFFE};
    tbl[11] = '{1, OP_OR,  LO, 16'h0100, 16'hFF00};
    tbl[12] = '{1, OP_AND, HI, 16'hFFF7, 16'hFFF0};
    tbl[13] = '{2, OP_XOR, HI, 16'h0001, 16'h0001};
    tbl[14] = '{2, OP_AND, HI, 16'h0000, 16'h0000};
    tbl[15] = '{2, OP_OR,  LO, 16'h0001, 16'h0001};

    reset_i   = 1'b1;
    auto_yumi = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, OP_AND, HI, 1'b1, 16'h0000);

    // Reset state.
    tick();
    check("reset v_o w8", {15'b0, get_vo(0)}, 16'd0);
    check("reset data_o w8", get_do(0), 16'h0000);
    check("reset v_o w16", {15'b0, get_vo(1)}, 16'd0);
    check("reset data_o w16", get_do(1), 16'h0000);
    reset_i = 1'b0;
    tick();
    check("ready after reset w8", {15'b0, get_ready(0)}, 16'd1);
    check("ready after reset w1", {15'b0, get_ready(2)}, 16'd1);

    // Table of isolated beats.
    for (int i = 0; i < 16; i++) begin
      run_beat($sformatf("vec%0d", i), tbl[i].sel, tbl[i].op, tbl[i].dir, 1'b1,
               tbl[i].data, tbl[i].exp);
    end
    tick();

    // Back-to-back beats come out on consecutive cycles.
    begin
      int cnt;
      drive(0, 1'b1, OP_XOR, HI, 1'b1, 16'h00FF);
      tick();
      drive(0, 1'b1, OP_OR, LO, 1'b1, 16'h0004);
      tick();
      drive(0, 1'b0, OP_OR, LO, 1'b1, 16'h0004);
      cnt = 0;
      while (!get_vo(0) && cnt < 20) begin
        tick();
        cnt++;
      end
      check("b2b first wait", 16'(cnt), 16'd1);
      check("b2b first data", get_do(0), 16'h00AA);
      tick();
      check("b2b second v_o", {15'b0, get_vo(0)}, 16'd1);
      check("b2b second data", get_do(0), 16'h00FC);
      tick();
      check("b2b drained v_o", {15'b0, get_vo(0)}, 16'd0);
    end

    // Stall with three beats in flight, then release.
    auto_yumi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, tbl[i].op, tbl[i].dir, 1'b1, tbl[i].data);
      exp_q.push_back(tbl[i].exp);
      tick();
    end
    drive(0, 1'b0, OP_AND, HI, 1'b1, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall ready c%0d", c), {15'b0, get_ready(0)}, 16'd0);
      check($sformatf("stall data c%0d", c), get_do(0), exp_q[0]);
    end
    auto_yumi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("release v_o %0d", i), {15'b0, get_vo(0)}, 16'd1);
      check($sformatf("release data %0d", i), get_do(0), exp_q.pop_front());
      tick();
    end
    check("release drained v_o", {15'b0, get_vo(0)}, 16'd0);

    // Asynchronous reset with a full pipe.
    auto_yumi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, tbl[i].op, tbl[i].dir, 1'b1, tbl[i].data);
      tick();
    end
    drive(0, 1'b0, OP_AND, HI, 1'b1, 16'h0000);
    check("pre-reset v_o", {15'b0, get_vo(0)}, 16'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("async reset v_o", {15'b0, get_vo(0)}, 16'd0);
    check("async reset data_o", get_do(0), 16'h0000);
    tick();
    reset_i   = 1'b0;
    auto_yumi = 1'b1;
    tick();
    check("post-reset ready", {15'b0, get_ready(0)}, 16'd1);
    tick();
    check("post-reset no stale v_o", {15'b0, get_vo(0)}, 16'd0);
    run_beat("post-reset beat", 0, OP_AND, HI, 1'b1, 16'h00DF, 16'h00C0);
    tick();

    // Cross-beat accumulation (beats independent when the feature is absent).
    run_beat("acc A", 0, OP_XOR, HI, 1'b0, 16'h0001, 16'h0001);
    run_beat("acc B", 0, OP_XOR, HI, 1'b1, 16'h0000, ACC_B_EXP);
    run_beat("acc C", 0, OP_XOR, HI, 1'b1, 16'h0000, 16'h0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
